rom_stream_reader: RTL and testbench
====================================

ROM_STREAM_READER -- requirements
Module: rom_stream_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, meaning the ROM read-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning the ROM data and stream word width.
REQ-003 SHALL have port CLKIN  input  1  the single clock, which also drives the ROM RCLK.
REQ-004 SHALL have port RESET  input  1  the reset, asynchronous and active-high.
REQ-005 SHALL have port START  input  1  burst request, sampled only in IDLE.
REQ-006 SHALL have port BASE  input  ADDR_WIDTH  first ROM address, captured with START.
REQ-007 SHALL have port LEN  input  ADDR_WIDTH+1  word count, captured with START, legal range 0..2^ADDR_WIDTH.
REQ-008 SHALL have port RADDR  output  ADDR_WIDTH  registered ROM read address.
REQ-009 SHALL have port RE  output  1  registered ROM read enable.
REQ-010 SHALL have port RDATA  input  DATA_WIDTH  ROM read data, valid one CLKIN edge after RADDR/RE are sampled.
REQ-011 SHALL have port DOUT  output  DATA_WIDTH  stream data.
REQ-012 SHALL have port VALID  output  1  DOUT holds a word.
REQ-013 SHALL have port READY  input  1  consumer accepts the word; a transfer occurs on a CLKIN edge with VALID and READY both high.
REQ-014 SHALL have port BUSY  output  1  high in RUN and DRAIN.
REQ-015 SHALL have port DONE  output  1  one-cycle pulse marking burst end.

Function
REQ-016 SHALL implement states IDLE, RUN and DRAIN.
REQ-017 In IDLE, START=1 with LEN>0 SHALL capture BASE and LEN and enter RUN; the first read issues on the same edge.
REQ-018 START with LEN=0 SHALL issue no reads, remain in IDLE and pulse DONE in the following cycle.
REQ-019 START SHALL be ignored while BUSY=1.
REQ-020 Each issued read SHALL drive RE=1 with RADDR equal to the next address; RE SHALL be 0 when no read issues.
REQ-021 The address SHALL increment modulo 2^ADDR_WIDTH, wrapping from all-ones to zero.
REQ-022 Returned RDATA SHALL be written into a 4-entry output FIFO two edges after issue; DOUT/VALID SHALL come from the FIFO head.
REQ-023 A read SHALL issue only when FIFO occupancy plus in-flight reads is less than 4; the FIFO SHALL never overflow, drop a word or duplicate a word.
REQ-024 With READY held high, words SHALL stream one per cycle, with the first VALID two cycles after the START edge.
REQ-025 After the LEN-th read issues, the block SHALL enter DRAIN.
REQ-026 DRAIN SHALL exit to IDLE on the edge where the last word transfers, and DONE SHALL be 1 for exactly the following cycle.
REQ-027 DOUT SHALL remain stable while VALID=1 and READY=0.

Reset
REQ-028 RESET=1 SHALL asynchronously force state IDLE, RE=0, RADDR=0, VALID=0, DOUT=0, BUSY=0, DONE=0, and clear the FIFO, in-flight count and word counter.
REQ-029 RESET during a burst SHALL abort it without a DONE pulse; ROM data returning after RESET SHALL be discarded.

Configuration
REQ-030 With ROM_STREAM_READER_LOOP_EN defined, an input port LOOP (1 bit) SHALL exist.
REQ-031 With ROM_STREAM_READER_LOOP_EN defined, if LOOP=1 when the LEN-th read issues, the address SHALL reload BASE, the count SHALL reload LEN and RUN SHALL continue with no gap and no DONE pulse.
REQ-032 Without ROM_STREAM_READER_LOOP_EN, the LOOP port SHALL be absent and every burst SHALL end per REQ-025/026.

Verification (ROM model: RDATA = previous-cycle RADDR; content equals address)
REQ-033 BASE=0x10, LEN=4, READY=1 -> DOUT 0x10,0x11,0x12,0x13 on 4 consecutive cycles; first VALID 2 cycles after START; DONE one cycle after the 0x13 transfer.
REQ-034 BASE=0xFE, LEN=4 -> DOUT 0xFE,0xFF,0x00,0x01.
REQ-035 BASE=0x00, LEN=8, READY toggled 1-0-0-1 repeating -> all 8 words delivered in order; DOUT stable while stalled; no more than 4 words outstanding; RE=0 while full.
REQ-036 LEN=0 -> RE never asserted, VALID never asserted, DONE pulses once; a second START while BUSY during a LEN=16 burst -> ignored, exactly 16 words delivered.
REQ-037 RESET asserted after the 3rd word of a LEN=10 burst -> all outputs at reset values immediately, no further VALID, no DONE; a new START with BASE=0x40, LEN=2 -> DOUT 0x40,0x41.
REQ-038 With ROM_STREAM_READER_LOOP_EN defined, LOOP=1, BASE=0x20, LEN=3 -> DOUT 0x20,0x21,0x22,0x20,0x21,0x22 gap-free; LOOP dropped -> DONE after the current pass.

Source files
------------

// File: rtl/rom_stream_reader.sv
// Streams LEN words from a synchronous ROM starting at BASE into a 4-entry output FIFO.
// Optional feature macro: ROM_STREAM_READER_LOOP_EN adds a LOOP input for gap-free burst repetition.
module rom_stream_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLKIN,
  input  logic                  RESET,
  input  logic                  START,
`ifdef ROM_STREAM_READER_LOOP_EN
  input  logic                  LOOP,
`endif
  input  logic [ADDR_WIDTH-1:0] BASE,
  input  logic [ADDR_WIDTH:0]   LEN,
  output logic [ADDR_WIDTH-1:0] RADDR,
  output logic                  RE,
  input  logic [DATA_WIDTH-1:0] RDATA,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  VALID,
  input  logic                  READY,
  output logic                  BUSY,
  output logic                  DONE
);

  // Stream handshake: a word moves on a CLKIN edge where VALID and READY are both high;
  // VALID never drops and DOUT never changes until that transfer happens.

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] base_q, next_addr, addr_issue, cap_base;
  logic [ADDR_WIDTH:0]   len_q, rem, rem_src, cap_len;
  logic                  pend;
  logic [DATA_WIDTH-1:0] mem [4];
  logic [1:0]            wr_ptr, rd_ptr;
  logic [2:0]            occ, total;
  logic                  issue, reload, load_start, done_next, last, space;
  logic                  push, pop, loop_en;

`ifdef ROM_STREAM_READER_LOOP_EN
  assign loop_en = LOOP;
`else
  assign loop_en = 1'b0;
`endif

  assign VALID = (occ != 3'd0);
  assign DOUT  = mem[rd_ptr];
  assign BUSY  = (state != IDLE);
  assign push  = pend;
  assign pop   = VALID && READY;
  // Occupancy plus reads still in the ROM pipeline (RE stage and pend stage).
  assign total = occ + {2'b00, RE} + {2'b00, pend};
  assign space = (total < 3'd4);

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    reload     = 1'b0;
    load_start = 1'b0;
    done_next  = 1'b0;
    addr_issue = next_addr;
    cap_base   = base_q;
    cap_len    = len_q;
    rem_src    = rem;
    case (state)
      IDLE: begin
        if (START) begin
          if (LEN == '0) begin
            done_next = 1'b1;
          end else begin
            issue      = 1'b1;
            load_start = 1'b1;
            addr_issue = BASE;
            cap_base   = BASE;
            cap_len    = LEN;
            rem_src    = LEN;
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (space) issue = 1'b1;
      end
      DRAIN: begin
        if (!RE && !pend && (occ == 3'd1) && pop) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    last = issue && (rem_src == LEN_ONE);
    if (last) begin
      if (loop_en) reload = 1'b1;
      else         state_next = DRAIN;
    end
  end

  always_ff @(posedge CLKIN or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      RE        <= 1'b0;
      RADDR     <= '0;
      DONE      <= 1'b0;
      base_q    <= '0;
      len_q     <= '0;
      next_addr <= '0;
      rem       <= '0;
      pend      <= 1'b0;
    end else begin
      state <= state_next;
      RE    <= issue;
      DONE  <= done_next;
      // pend marks ROM data that will be valid on RDATA at the next edge.
      pend  <= RE;
      if (issue) RADDR <= addr_issue;
      if (load_start) begin
        base_q <= BASE;
        len_q  <= LEN;
      end
      if (issue) begin
        if (reload) begin
          next_addr <= cap_base;
          rem       <= cap_len;
        end else begin
          next_addr <= addr_issue + ADDR_ONE;
          rem       <= rem_src - LEN_ONE;
        end
      end
    end
  end

  always_ff @(posedge CLKIN or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      occ    <= 3'd0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= RDATA;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   occ <= occ + 3'd1;
        2'b01:   occ <= occ - 3'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench for rom_stream_reader: table of bursts, random bursts, reset abort, optional loop mode.
module tb_rom_stream_reader;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          CLKIN = 1'b0;
  logic          RESET = 1'b0;
  logic          START = 1'b0;
  logic          READY = 1'b0;
  logic [AW-1:0] BASE  = '0;
  logic [AW:0]   LEN   = '0;
  logic [AW-1:0] RADDR;
  logic          RE;
  logic [DW-1:0] RDATA = '0;
  logic [DW-1:0] DOUT;
  logic          VALID, BUSY, DONE;
`ifdef ROM_STREAM_READER_LOOP_EN
  logic          LOOP = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   len;
    int            mode;      // 0: READY high, 1: 1-0-0-1 pattern, 2: random
    bit            busy_start;
    int            exp_done;  // sample index of DONE after the START edge, -1 = not fixed
  } vec_t;
  vec_t vecs[6];

  rom_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLKIN(CLKIN),
    .RESET(RESET),
    .START(START),
`ifdef ROM_STREAM_READER_LOOP_EN
    .LOOP(LOOP),
`endif
    .BASE(BASE),
    .LEN(LEN),
    .RADDR(RADDR),
    .RE(RE),
    .RDATA(RDATA),
    .DOUT(DOUT),
    .VALID(VALID),
    .READY(READY),
    .BUSY(BUSY),
    .DONE(DONE)
  );

  always #5 CLKIN = ~CLKIN;

  // ROM whose content equals its address, one edge of read latency.
  always @(posedge CLKIN) RDATA <= RADDR;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return ((k % 4) == 0) || ((k % 4) == 3);
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  task automatic run_burst(input logic [AW-1:0] base, input logic [AW:0] len, input int mode,
                           input bit busy_start, input int exp_done, input string name);
    int issued, delivered, first_valid, last_t, budget;
    bit hold, prev_full, done_seen;
    logic [DW-1:0] held;
    logic [AW-1:0] ea;
    exp_q.delete();
    for (int i = 0; i < int'(len); i++) begin
      ea = base + i[AW-1:0];
      exp_q.push_back(ea);
    end
    issued = 0; delivered = 0; first_valid = -1; last_t = 0;
    hold = 0; prev_full = 0; done_seen = 0; held = '0;
    budget = 8 * int'(len) + 20;
    @(negedge CLKIN);
    START = 1'b1; BASE = base; LEN = len; READY = rdy(mode, 0);
    for (int k = 0; k < budget; k++) begin
      @(negedge CLKIN);
      START = 1'b0;
      if (busy_start && k == 3) begin
        check({name, "_busy_at_restart"}, BUSY, 1);
        START = 1'b1; BASE = 8'h99; LEN = 9'd5;
      end
      if (prev_full) check({name, "_re_while_full"}, RE, 0);
      if (RE) begin
        ea = base + issued[AW-1:0];
        check({name, "_raddr"}, RADDR, ea);
        issued++;
        check({name, "_outstanding_le4"}, (issued - delivered) <= 4, 1);
      end
      prev_full = ((issued - delivered) == 4);
      if (VALID && first_valid < 0) first_valid = k;
      if (hold) begin
        check({name, "_stall_valid"}, VALID, 1);
        check({name, "_stall_dout"}, DOUT, held);
      end
      if (DONE) begin
        done_seen = 1;
        check({name, "_done_after_last"}, k, last_t);
        if (exp_done >= 0) check({name, "_done_cycle"}, k, exp_done);
        check({name, "_words_left"}, exp_q.size(), 0);
        @(negedge CLKIN);
        check({name, "_done_one_cycle"}, DONE, 0);
        check({name, "_idle_after_done"}, BUSY, 0);
        break;
      end
      READY = rdy(mode, k + 1);
      hold = VALID && !READY;
      held = DOUT;
      if (VALID && READY) begin
        if (exp_q.size() == 0) check({name, "_extra_word"}, 1, 0);
        else check({name, "_dout"}, DOUT, exp_q.pop_front());
        delivered++;
        last_t = k + 1;
      end
    end
    READY = 1'b0;
    check({name, "_done_seen"}, done_seen, 1);
    check({name, "_reads_issued"}, issued, int'(len));
    check({name, "_first_valid"}, first_valid, (len == 0) ? -1 : 2);
  endtask

  initial begin
    int n;
    vecs[0] = '{base: 8'h10, len: 9'd4,   mode: 0, busy_start: 0, exp_done: 6};
    vecs[1] = '{base: 8'hFE, len: 9'd4,   mode: 0, busy_start: 0, exp_done: 6};
    vecs[2] = '{base: 8'h00, len: 9'd8,   mode: 1, busy_start: 0, exp_done: -1};
    vecs[3] = '{base: 8'h33, len: 9'd0,   mode: 0, busy_start: 0, exp_done: 0};
    vecs[4] = '{base: 8'hF0, len: 9'd16,  mode: 0, busy_start: 1, exp_done: 18};
    vecs[5] = '{base: 8'h80, len: 9'd256, mode: 0, busy_start: 0, exp_done: 258};

    #1 RESET = 1'b1;
    #1;
    check("reset_re", RE, 0);
    check("reset_raddr", RADDR, 0);
    check("reset_valid", VALID, 0);
    check("reset_dout", DOUT, 0);
    check("reset_busy", BUSY, 0);
    check("reset_done", DONE, 0);
    @(negedge CLKIN); @(negedge CLKIN);
    RESET = 1'b0;

    for (int v = 0; v < 6; v++)
      run_burst(vecs[v].base, vecs[v].len, vecs[v].mode, vecs[v].busy_start, vecs[v].exp_done,
                $sformatf("vec%0d", v));

    for (int r = 0; r < 12; r++)
      run_burst(AW'($urandom_range(0, 255)), 9'($urandom_range(0, 20)), 2, 0, -1,
                $sformatf("rand%0d", r));

    // Abort a LEN=10 burst right after its third word.
    @(negedge CLKIN);
    START = 1'b1; BASE = 8'h00; LEN = 9'd10; READY = 1'b1;
    n = 0;
    for (int k = 0; k < 30 && n < 3; k++) begin
      @(negedge CLKIN);
      START = 1'b0;
      if (VALID) n++;
    end
    check("abort_three_words", n, 3);
    @(negedge CLKIN);
    RESET = 1'b1;
    #1;
    check("abort_re", RE, 0);
    check("abort_raddr", RADDR, 0);
    check("abort_valid", VALID, 0);
    check("abort_dout", DOUT, 0);
    check("abort_busy", BUSY, 0);
    check("abort_done", DONE, 0);
    @(negedge CLKIN); @(negedge CLKIN);
    RESET = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLKIN);
      check("abort_quiet_valid", VALID, 0);
      check("abort_quiet_done", DONE, 0);
      check("abort_quiet_re", RE, 0);
    end
    READY = 1'b0;
    run_burst(8'h40, 9'd2, 0, 0, 4, "after_reset");

`ifdef ROM_STREAM_READER_LOOP_EN
    begin
      bit seen, fin;
      LOOP = 1'b1;
      @(negedge CLKIN);
      START = 1'b1; BASE = 8'h20; LEN = 9'd3; READY = 1'b1;
      n = 0; seen = 0; fin = 0;
      for (int k = 0; k < 60; k++) begin
        @(negedge CLKIN);
        START = 1'b0;
        if (seen && n < 6) check("loop_gap_free", VALID, 1);
        if (VALID) begin
          check("loop_dout", DOUT, 8'h20 + 8'(n % 3));
          n++;
          seen = 1;
        end
        if (n >= 6) LOOP = 1'b0;
        if (DONE) begin
          check("loop_done_after_six", n >= 6, 1);
          check("loop_whole_passes", n % 3, 0);
          fin = 1;
          break;
        end
      end
      check("loop_done_seen", fin, 1);
      READY = 1'b0;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
